// File: rtl/sprite_compositor_pkg.sv
// Shared constants, position-table entry and capture FSM encoding for the
// front-panel sprite compositor.
package sprite_compositor_pkg;

  localparam int unsigned DEF_SPRITE_SIZE   = 16;
  localparam int unsigned DEF_SPRITE_STRIDE = 32;

  localparam logic [11:0] DEF_LED_KEY     = 12'hF00;
  localparam logic [11:0] DEF_SW_KEY      = 12'h0F0;
  localparam logic [11:0] DEF_TRANSPARENT = 12'h333;
  localparam logic [11:0] DEF_KEY_FILL    = 12'h333;

  localparam logic [2:0] DEF_SPR_LED_OFF = 3'd5;
  localparam logic [2:0] DEF_SPR_LED_ON  = 3'd4;
  localparam logic [2:0] DEF_SPR_SW_DOWN = 3'd1;
  localparam logic [2:0] DEF_SPR_SW_UP   = 3'd0;

  localparam int unsigned ROM_ADDR_W = 13;
  localparam int unsigned PAL_IDX_W  = 8;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        valid;
  } pos_entry_t;

  typedef enum logic [1:0] {
    WAIT_FRAME,
    CAPTURE,
    LOCKED
  } cap_state_t;

endpackage

// File: rtl/sprite_compositor_box_match.sv
// Point-in-box search over a position table: lowest valid index whose
// SIZE x SIZE box contains the point, plus the point's offset in that box.
module box_match_array
  import sprite_compositor_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned SIZE  = 16,
  parameter int unsigned OFF_W = 5,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [10:0]          px,
  input  logic [10:0]          py,
  input  pos_entry_t [N-1:0]   table_in,
  output logic                 hit,
  output logic [IDX_W-1:0]     idx,
  output logic [OFF_W-1:0]     dx,
  output logic [OFF_W-1:0]     dy
);

  logic [N-1:0] match;

  // 12-bit compares so boxes near x=2047 do not wrap.
  for (genvar i = 0; i < N; i++) begin : g_ent
    assign match[i] = table_in[i].valid
                   && ({1'b0, px} >= {1'b0, table_in[i].x})
                   && ({1'b0, px} <  {1'b0, table_in[i].x} + 12'(SIZE))
                   && ({1'b0, py} >= {1'b0, table_in[i].y})
                   && ({1'b0, py} <  {1'b0, table_in[i].y} + 12'(SIZE));
  end

  always_comb begin
    hit = 1'b0;
    idx = '0;
    dx  = '0;
    dy  = '0;
    for (int unsigned i = N; i > 0; i--) begin
      if (match[i-1]) begin
        hit = 1'b1;
        idx = IDX_W'(i - 1);
        dx  = OFF_W'(px - table_in[i-1].x);
        dy  = OFF_W'(py - table_in[i-1].y);
      end
    end
  end

endmodule

// File: rtl/sram_image.sv
// Registered-read image store holding the sprite index bitmap (IMAGE=0)
// or the RGB444 palette (IMAGE=1).
module sram_image #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMAGE  = 0
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  if (IMAGE == 0) begin : g_sprite
    always_ff @(posedge clk)
      data <= DATA_W'(addr[7:0] ^ 8'(addr >> 8));
  end else begin : g_palette
    always_ff @(posedge clk)
      data <= (addr[7:0] == 8'd0) ? DATA_W'(12'h333)
                                  : DATA_W'({addr[3:0], addr[7:4], addr[3:0] ^ addr[7:4]});
  end

endmodule

// File: rtl/sprite_compositor.sv
// Front-panel overlay: captures LED/switch positions from marker pixels,
// composites state sprites over the background, reports switch clicks.
module sprite_compositor
  import sprite_compositor_pkg::*;
#(
  parameter int unsigned        NUM_LEDS      = 36,
  parameter int unsigned        NUM_SWITCHES  = 25,
  parameter int unsigned        COLOR_W       = 12,
  parameter int unsigned        SPRITE_SIZE   = DEF_SPRITE_SIZE,
  parameter int unsigned        SPRITE_STRIDE = DEF_SPRITE_STRIDE,
  parameter logic [COLOR_W-1:0] LED_KEY       = COLOR_W'(DEF_LED_KEY),
  parameter logic [COLOR_W-1:0] SW_KEY        = COLOR_W'(DEF_SW_KEY),
  parameter logic [COLOR_W-1:0] TRANSPARENT   = COLOR_W'(DEF_TRANSPARENT),
  parameter logic [COLOR_W-1:0] KEY_FILL      = COLOR_W'(DEF_KEY_FILL),
  parameter logic [2:0]         SPR_LED_OFF   = DEF_SPR_LED_OFF,
  parameter logic [2:0]         SPR_LED_ON    = DEF_SPR_LED_ON,
  parameter logic [2:0]         SPR_SW_DOWN   = DEF_SPR_SW_DOWN,
  parameter logic [2:0]         SPR_SW_UP     = DEF_SPR_SW_UP
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    frame_start,
  input  logic                    rescan,
  input  logic [10:0]             current_x,
  input  logic [10:0]             current_y,
  input  logic [COLOR_W-1:0]      background_color,
  input  logic [NUM_LEDS-1:0]     led_state,
  input  logic [NUM_SWITCHES-1:0] switch_state,
  input  logic [10:0]             cursor_x,
  input  logic [9:0]              cursor_y,
  input  logic                    cursor_clicked,
  output logic [COLOR_W-1:0]      color,
  output logic                    locked,
  output logic [5:0]              led_count,
  output logic [4:0]              switch_count,
  output logic                    switch_hit,
  output logic [4:0]              switch_hit_idx
);

  localparam int unsigned LED_IDX_W = $clog2(NUM_LEDS);
  localparam int unsigned SW_IDX_W  = $clog2(NUM_SWITCHES);
  localparam int unsigned OFF_W     = $clog2(SPRITE_STRIDE);

  cap_state_t state_q, state_d;

  pos_entry_t [NUM_LEDS-1:0]     led_tab;
  pos_entry_t [NUM_SWITCHES-1:0] sw_tab;

  logic                 led_hit, sw_hit, cur_hit;
  logic [LED_IDX_W-1:0] led_idx;
  logic [SW_IDX_W-1:0]  sw_idx, cur_idx;
  logic [OFF_W-1:0]     led_dx, led_dy, sw_dx, sw_dy;
  logic [OFF_W-1:0]     unused_cur_dx, unused_cur_dy;

  box_match_array #(.N(NUM_LEDS), .SIZE(SPRITE_SIZE), .OFF_W(OFF_W)) u_led_match (
    .px(current_x), .py(current_y), .table_in(led_tab),
    .hit(led_hit), .idx(led_idx), .dx(led_dx), .dy(led_dy)
  );

  box_match_array #(.N(NUM_SWITCHES), .SIZE(SPRITE_SIZE), .OFF_W(OFF_W)) u_sw_match (
    .px(current_x), .py(current_y), .table_in(sw_tab),
    .hit(sw_hit), .idx(sw_idx), .dx(sw_dx), .dy(sw_dy)
  );

  box_match_array #(.N(NUM_SWITCHES), .SIZE(SPRITE_SIZE), .OFF_W(OFF_W)) u_cursor_match (
    .px(cursor_x), .py({1'b0, cursor_y}), .table_in(sw_tab),
    .hit(cur_hit), .idx(cur_idx), .dx(unused_cur_dx), .dy(unused_cur_dy)
  );

  // ---------------- capture FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) state_q <= WAIT_FRAME;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (rescan) begin
      state_d = WAIT_FRAME;
    end else begin
      case (state_q)
        WAIT_FRAME: if (frame_start) state_d = CAPTURE;
        CAPTURE:    if (frame_start) state_d = LOCKED;
        default:    ;
      endcase
    end
  end

  assign locked = (state_q == LOCKED);

  logic cap_en, led_store, sw_store;

  // The box-match hit doubles as the one-slot-per-blob filter.
  assign cap_en    = (state_q == CAPTURE) && !frame_start && !rescan;
  assign led_store = cap_en && (background_color == LED_KEY)
                  && (led_count < 6'(NUM_LEDS)) && !led_hit;
  assign sw_store  = cap_en && (background_color == SW_KEY)
                  && (switch_count < 5'(NUM_SWITCHES)) && !sw_hit;

  always_ff @(posedge clk) begin
    if (reset || rescan) begin
      led_count    <= '0;
      switch_count <= '0;
      for (int unsigned i = 0; i < NUM_LEDS; i++)     led_tab[i].valid <= 1'b0;
      for (int unsigned i = 0; i < NUM_SWITCHES; i++) sw_tab[i].valid  <= 1'b0;
    end else begin
      if (led_store) begin
        led_tab[led_count] <= '{x: current_x, y: current_y, valid: 1'b1};
        led_count          <= led_count + 6'd1;
      end
      if (sw_store) begin
        sw_tab[switch_count] <= '{x: current_x, y: current_y, valid: 1'b1};
        switch_count         <= switch_count + 5'd1;
      end
    end
  end

  // ---------------- composite pipeline ----------------
  logic [2:0]            slot;
  logic [OFF_W-1:0]      ofs_x, ofs_y;
  logic                  hit_d;
  logic [ROM_ADDR_W-1:0] rom_addr_d, rom_addr_s1;
  logic [PAL_IDX_W-1:0]  rom_data;
  logic [COLOR_W-1:0]    pal_color;
  logic [COLOR_W-1:0]    bg_s1, bg_s2, bg_s3;
  logic [2:0]            v_pipe, hit_pipe;

  always_comb begin
    slot  = '0;
    ofs_x = led_dx;
    ofs_y = led_dy;
    hit_d = 1'b0;
    if (led_hit) begin
      hit_d = 1'b1;
      slot  = led_state[led_idx] ? SPR_LED_ON : SPR_LED_OFF;
    end else if (sw_hit) begin
      hit_d = 1'b1;
      slot  = switch_state[sw_idx] ? SPR_SW_UP : SPR_SW_DOWN;
      ofs_x = sw_dx;
      ofs_y = sw_dy;
    end
    rom_addr_d = ROM_ADDR_W'(32'(ofs_x) + 32'(ofs_y) * SPRITE_STRIDE
                             + 32'(slot) * SPRITE_STRIDE * SPRITE_STRIDE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_pipe   <= '0;
      hit_pipe <= '0;
    end else begin
      v_pipe   <= {v_pipe[1:0], 1'b1};
      hit_pipe <= {hit_pipe[1:0], hit_d};
    end
  end

  always_ff @(posedge clk) begin
    rom_addr_s1 <= rom_addr_d;
    bg_s1       <= background_color;
    bg_s2       <= bg_s1;
    bg_s3       <= bg_s2;
  end

  sram_image #(.ADDR_W(ROM_ADDR_W), .DATA_W(PAL_IDX_W), .IMAGE(0)) u_sprite_rom (
    .clk(clk), .addr(rom_addr_s1), .data(rom_data)
  );

  sram_image #(.ADDR_W(PAL_IDX_W), .DATA_W(COLOR_W), .IMAGE(1)) u_palette (
    .clk(clk), .addr(rom_data), .data(pal_color)
  );

  always_ff @(posedge clk) begin
    if (reset || !v_pipe[2])                          color <= '0;
    else if (hit_pipe[2] && pal_color != TRANSPARENT) color <= pal_color;
    else if (bg_s3 == LED_KEY || bg_s3 == SW_KEY)     color <= KEY_FILL;
    else                                              color <= bg_s3;
  end

  // ---------------- click detection ----------------
  logic click_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      click_prev     <= 1'b0;
      switch_hit     <= 1'b0;
      switch_hit_idx <= '0;
    end else begin
      click_prev <= cursor_clicked;
      switch_hit <= cursor_clicked && !click_prev && locked && cur_hit;
      if (cursor_clicked && !click_prev && locked && cur_hit)
        switch_hit_idx <= 5'(cur_idx);
    end
  end

endmodule

// File: tb/tb_sprite_compositor.sv
// Randomised/directed bench for sprite_compositor against a behavioural
// model of capture, compositing and click rules.
module tb_sprite_compositor;

  logic        clk = 1'b0;
  logic        reset, frame_start, rescan;
  logic [10:0] current_x, current_y;
  logic [11:0] background_color;
  logic [35:0] led_state;
  logic [24:0] switch_state;
  logic [10:0] cursor_x;
  logic [9:0]  cursor_y;
  logic        cursor_clicked;
  logic [11:0] color;
  logic        locked;
  logic [5:0]  led_count;
  logic [4:0]  switch_count;
  logic        switch_hit;
  logic [4:0]  switch_hit_idx;

  always #5 clk = ~clk;

  sprite_compositor dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .rescan(rescan),
    .current_x(current_x), .current_y(current_y), .background_color(background_color),
    .led_state(led_state), .switch_state(switch_state),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .cursor_clicked(cursor_clicked),
    .color(color), .locked(locked), .led_count(led_count), .switch_count(switch_count),
    .switch_hit(switch_hit), .switch_hit_idx(switch_hit_idx)
  );

  int checks = 0;
  int passed = 0;

  // model: mode 0 waiting, 1 capturing, 2 locked
  int          mode;
  int          lx[$], ly[$], sx[$], sy[$];
  logic [11:0] expq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int rom_m(int a);
    return (a % 256) ^ (a / 256);
  endfunction

  function automatic logic [11:0] pal_m(int i);
    if (i == 0) return 12'h333;
    return 12'((i % 16) * 256 + (i / 16) * 16 + ((i % 16) ^ (i / 16)));
  endfunction

  function automatic bit in_box(int x, int y, int x0, int y0);
    return x >= x0 && x < x0 + 16 && y >= y0 && y < y0 + 16;
  endfunction

  function automatic int first_in(input int qx[$], input int qy[$], int x, int y);
    foreach (qx[i]) if (in_box(x, y, qx[i], qy[i])) return i;
    return -1;
  endfunction

  function automatic logic [11:0] model_color(int x, int y, logic [11:0] bg);
    int slot = -1, ox = 0, oy = 0, i;
    logic [11:0] p;
    i = first_in(lx, ly, x, y);
    if (i >= 0) begin
      slot = led_state[i] ? 4 : 5; ox = x - lx[i]; oy = y - ly[i];
    end else begin
      i = first_in(sx, sy, x, y);
      if (i >= 0) begin
        slot = switch_state[i] ? 0 : 1; ox = x - sx[i]; oy = y - sy[i];
      end
    end
    if (slot >= 0) begin
      p = pal_m(rom_m((ox + 32 * oy + 1024 * slot) % 8192));
      if (p != 12'h333) return p;
    end
    if (bg == 12'hF00 || bg == 12'h0F0) return 12'h333;
    return bg;
  endfunction

  task automatic model_clear();
    lx.delete(); ly.delete(); sx.delete(); sy.delete();
    mode = 0;
  endtask

  task automatic model_update(int x, int y, logic [11:0] bg, bit fs, bit rs);
    if (rs) model_clear();
    else if (fs) begin
      if (mode == 0) mode = 1;
      else if (mode == 1) mode = 2;
    end else if (mode == 1) begin
      if (bg == 12'hF00 && lx.size() < 36 && first_in(lx, ly, x, y) < 0) begin
        lx.push_back(x); ly.push_back(y);
      end
      if (bg == 12'h0F0 && sx.size() < 25 && first_in(sx, sy, x, y) < 0) begin
        sx.push_back(x); sy.push_back(y);
      end
    end
  endtask

  function automatic logic [11:0] rnd_bg();
    logic [11:0] r;
    do r = 12'($urandom_range(0, 4095)); while (r == 12'hF00 || r == 12'h0F0);
    return r;
  endfunction

  task automatic step(int x, int y, logic [11:0] bg, bit fs = 1'b0, bit rs = 1'b0);
    current_x = 11'(x); current_y = 11'(y); background_color = bg;
    frame_start = fs; rescan = rs;
    expq.push_back(model_color(x, y, bg));
    model_update(x, y, bg, fs, rs);
    @(posedge clk); #1;
    frame_start = 1'b0; rescan = 1'b0;
    if (expq.size() == 4) chk("color", 32'(color), 32'(expq.pop_front()));
  endtask

  task automatic idle();
    step(1500, 900, rnd_bg());
  endtask

  task automatic do_reset();
    reset = 1'b1; frame_start = 1'b0; rescan = 1'b0; cursor_clicked = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    expq.delete();
    model_clear();
    chk("rst_color", 32'(color), 32'h0);
    chk("rst_locked", 32'(locked), 32'h0);
    chk("rst_led_count", 32'(led_count), 32'h0);
    chk("rst_switch_count", 32'(switch_count), 32'h0);
    chk("rst_switch_hit", 32'(switch_hit), 32'h0);
  endtask

  task automatic click(int cx, int cy);
    int pulses = 0, first_at = -1, idx_seen = -1, exp_idx;
    cursor_x = 11'(cx); cursor_y = 10'(cy); cursor_clicked = 1'b0;
    idle();
    exp_idx = (mode == 2) ? first_in(sx, sy, cx, cy) : -1;
    cursor_clicked = 1'b1;
    for (int i = 0; i < 10; i++) begin
      idle();
      if (switch_hit) begin
        pulses++;
        if (first_at < 0) first_at = i;
        idx_seen = int'(switch_hit_idx);
      end
    end
    cursor_clicked = 1'b0;
    idle();
    chk("hit_pulses", 32'(pulses), (exp_idx >= 0) ? 32'd1 : 32'd0);
    chk("hit_timing", 32'(first_at), (exp_idx >= 0) ? 32'd0 : 32'hFFFF_FFFF);
    chk("hit_idx", 32'(idx_seen), 32'(exp_idx));
  endtask

  task automatic scan_led_block(int y_lo, int y_hi);
    for (int y = y_lo; y <= y_hi; y++)
      for (int x = 96; x <= 120; x++)
        step(x, y, in_box(x, y, 100, 50) ? 12'hF00 : rnd_bg());
  endtask

  task automatic random_composite(int n);
    int x, y;
    logic [11:0] bg;
    for (int k = 0; k < n; k++) begin
      led_state    = 36'({$urandom(), $urandom()});
      switch_state = 25'($urandom());
      if ($urandom_range(0, 1) == 1) begin
        x = $urandom_range(88, 132); y = $urandom_range(40, 76);
      end else begin
        x = $urandom_range(388, 424); y = $urandom_range(190, 226);
      end
      if ($urandom_range(0, 5) == 0) bg = ($urandom_range(0, 1) == 1) ? 12'hF00 : 12'h0F0;
      else bg = rnd_bg();
      step(x, y, bg);
    end
  endtask

  initial begin
    reset = 1'b1; frame_start = 1'b0; rescan = 1'b0;
    current_x = '0; current_y = '0; background_color = '0;
    led_state = '0; switch_state = '0;
    cursor_x = 11'd1800; cursor_y = 10'd1000; cursor_clicked = 1'b0;
    do_reset();

    // first capture frame: LED block at (100,50), switch block at (400,200)
    step(0, 0, 12'h000, 1'b1);
    scan_led_block(45, 70);
    for (int y = 198; y <= 220; y++)
      for (int x = 396; x <= 420; x++)
        step(x, y, in_box(x, y, 400, 200) ? 12'h0F0 : rnd_bg());
    step(0, 0, 12'h000, 1'b1);
    chk("locked_after_capture", 32'(locked), 32'd1);
    chk("led_count_block", 32'(led_count), 32'(lx.size()));
    chk("switch_count_block", 32'(switch_count), 32'(sx.size()));
    chk("led_entry_count_is_one", 32'(led_count), 32'd1);

    // directed LED pixel, on then off, then randomised compositing
    led_state = 36'h1;  step(103, 52, 12'h000);
    led_state = 36'h0;  step(103, 52, 12'h000);
    switch_state = 25'h0; step(404, 200, 12'h0A0);
    step(300, 300, 12'hF00);
    random_composite(300);

    click(405, 210);
    click(420, 200);

    // rescan from LOCKED, then 40-marker capture with a click while capturing
    step(1500, 900, rnd_bg(), 1'b0, 1'b1);
    chk("rescan_locked", 32'(locked), 32'd0);
    chk("rescan_led_count", 32'(led_count), 32'd0);
    step(0, 0, 12'h000, 1'b1);
    for (int i = 0; i < 40; i++) begin
      step(30 + 45 * (i % 10), 300 + 40 * (i / 10), 12'hF00);
      step(33 + 45 * (i % 10), 304 + 40 * (i / 10), rnd_bg());
    end
    step(400, 200, 12'h0F0);
    click(405, 210);
    step(0, 0, 12'h000, 1'b1);
    chk("led_count_saturated", 32'(led_count), 32'd36);
    chk("switch_count_frame2", 32'(switch_count), 32'd1);
    for (int i = 0; i < 40; i++) begin
      led_state = 36'({$urandom(), $urandom()});
      step(30 + 45 * (i % 10), 300 + 40 * (i / 10), 12'hF00);
      step(31 + 45 * (i % 10), 301 + 40 * (i / 10), rnd_bg());
    end
    click(405, 210);

    // rescan, start a capture, then reset mid-capture
    step(1500, 900, rnd_bg(), 1'b0, 1'b1);
    step(0, 0, 12'h000, 1'b1);
    scan_led_block(50, 52);
    do_reset();

    step(0, 0, 12'h000, 1'b1);
    scan_led_block(48, 67);
    step(0, 0, 12'h000, 1'b1);
    chk("recapture_locked", 32'(locked), 32'd1);
    chk("recapture_led_count", 32'(led_count), 32'd1);
    random_composite(100);
    repeat (4) idle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
- Parametrised successor to the front-panel pixel overlay stage, sitting between the background VRAM lookup and the video output.
- During a capture frame it learns LED and switch positions from key-coloured marker pixels in the background image.
- It then composites state-dependent sprites (LED on/off, switch up/down) over the background with a fixed 4-cycle pipeline.
- It reports cursor clicks on switches as one-cycle hit pulses.

Parameters:
NUM_LEDS, 36, LED slots in position table
NUM_SWITCHES, 25, switch slots in position table
COLOR_W, 12, RGB444 colour width
SPRITE_SIZE, 16, visible square sprite edge in pixels
SPRITE_STRIDE, 32, row pitch and per-sprite height in sprite ROM
LED_KEY, 12'hF00, background marker colour for LEDs
SW_KEY, 12'h0F0, background marker colour for switches
TRANSPARENT, 12'h333, sprite colour treated as see-through
KEY_FILL, 12'h333, colour output in place of marker pixels
SPR_LED_OFF/SPR_LED_ON/SPR_SW_DOWN/SPR_SW_UP, 5/4/1/0, sprite ROM slot indices

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous active-high reset
frame_start  in  1  one-cycle pulse at pixel (0,0)
rescan  in  1  pulse: clear tables, recapture next frame
current_x  in  11  pixel x
current_y  in  11  pixel y
background_color  in  COLOR_W  background pixel, aligned with current_x/y
led_state  in  NUM_LEDS  1 = LED lit
switch_state  in  NUM_SWITCHES  1 = switch up
cursor_x  in  11  cursor x
cursor_y  in  10  cursor y
cursor_clicked  in  1  level, mouse button held
color  out  COLOR_W  composited pixel, 4 cycles after inputs
locked  out  1  position tables valid
led_count  out  6  LEDs captured
switch_count  out  5  switches captured
switch_hit  out  1  one-cycle pulse, click landed on a switch
switch_hit_idx  out  5  switch index for switch_hit

Behaviour:
- Reset and outputs:
  - Clock is clk; reset is synchronous and active-high.
  - On reset: color=0, locked=0, counts=0, switch_hit=0, switch_hit_idx=0, entry valid bits cleared, FSM=WAIT_FRAME, pipeline valid bits cleared.
- FSM:
  - WAIT_FRAME: frame_start moves to CAPTURE.
  - CAPTURE: the next frame_start moves to LOCKED and sets locked=1.
  - LOCKED: rescan clears counts and valid bits and moves to WAIT_FRAME.
  - rescan in any state behaves the same way.
  - reset mid-capture discards the partial table.
- Capture rule (CAPTURE only):
  - Stores a slot when the pixel equals the key, the count is below the limit, and (x,y) is not inside any valid same-type box [x0,x0+SPRITE_SIZE)×[y0,y0+SPRITE_SIZE).
  - Consequence: one slot per marker blob, located at its top-left-first raster pixel.
  - Overflowing markers are ignored; count saturates at NUM_*.
- Composite (all states):
  - Stage 1 compares the pixel against all valid boxes.
  - Priority: LED over switch, then lowest index.
  - ROM address = (x−x0) + SPRITE_STRIDE·(y−y0) + SPRITE_STRIDE·SPRITE_STRIDE·slot.
    - Slot is chosen by state bit: LED on→SPR_LED_ON, off→SPR_LED_OFF; switch up→SPR_SW_UP, down→SPR_SW_DOWN.
    - Computed at 13 bits, modulo 2^13.
  - Comparisons are unsigned 12-bit to avoid wrap at x0+SIZE>2047.
  - Stage 2: sprite ROM read. Stage 3: palette read.
  - Stage 4 colour register, in priority order:
    - hit and palette≠TRANSPARENT → palette colour;
    - else background∈{LED_KEY,SW_KEY} → KEY_FILL;
    - else background (delayed 3 stages).
  - Latency is exactly 4 cycles and the pipeline is never stalled.
  - While unlocked, pixels in previously captured boxes still composite.
- Click detection:
  - Rising edge of cursor_clicked (registered previous value) while locked.
  - If the cursor lies inside a valid switch box, switch_hit pulses on the next cycle with the lowest matching index.
  - Held button produces no further pulses.
  - No pulse when not locked or no match.

Decomposition:
- Package sprite_compositor_pkg: colour constants (keys, TRANSPARENT, KEY_FILL), sprite slot indices, SPRITE_SIZE/STRIDE, and the position-entry struct (x 11b, y 11b, valid).
- One natural sub-module: box_match_array (parametrised N).
  - Inputs: point and table.
  - Outputs: hit, lowest matching index, dx, dy.
  - Instantiated three times: LEDs, switches, cursor-vs-switches.
- Sprite ROM and palette reuse the existing sram_image instances.

Test Plan:
- Reset then frame_start, one frame with a 16×16 F00 block at (100,50), then frame_start → locked=1, led_count=1, entry=(100,50); no duplicate slots from the block's other 255 pixels.
- Locked, led_state[0]=1, present pixel (103,52) with background 0x000 → color exactly 4 cycles later equals palette[ROM[3+32·2+1024·4]]. With led_state[0]=0 the ROM address uses slot 5.
- Palette returns 0x333 at a hit pixel with background 0x0A0 → color=0x0A0. Marker pixel F00 outside any sprite region → color=0x333.
- 40 separated F00 markers in one capture frame → led_count saturates at 36; markers 37–40 render as 0x333 only.
- Switch captured at (400,200); cursor (405,210), cursor_clicked 0→1 held 10 cycles → exactly one switch_hit pulse with idx=0. Cursor at (420,200) → no pulse.
- Assert rescan mid-LOCKED, then reset asserted during CAPTURE → counts=0, locked=0, color=0 the cycle after reset; recapture in the next frame succeeds.
